// File: rtl/video_fetch.sv
`default_nettype none
// ============================================================================
// Module   : video_fetch
// Brief    : Fetches one video line of LINE_BYTES bytes from SRAM through a
//            single-outstanding read port into a small prefetch FIFO that the
//            pixel consumer drains.
// Revision : 1.0 - initial release
// ============================================================================
module video_fetch #(
  parameter int LINE_BYTES = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        line_start,
  input  logic [14:0] base_addr,
  output logic [14:0] rd_addr,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic [7:0]  ram_data,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_pop,
  output logic        busy,
  output logic        err
);

  localparam int              c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
  localparam logic [7:0]      c_LINE  = 8'(LINE_BYTES);

  // FETCH means a read is outstanding; HOLD means bytes remain but the FIFO is full
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [14:0]     r_addr;
  logic [7:0]      r_remaining;
  logic [7:0]      w_rem_dec;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW-1:0] w_rptr_inc;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_count_next;
  logic            r_rd_req;
  logic            r_busy;
  logic            r_err;
  logic [7:0]      r_pix_data;
  logic            w_start;
  logic            w_ack;
  logic            w_pop;
  logic            w_empty;

  assign w_empty    = (r_count == '0);
  assign w_start    = line_start && (r_state == IDLE);
  assign w_ack      = rd_ack && (r_state == FETCH);
  assign w_pop      = pix_pop && !w_empty;
  assign w_rem_dec  = r_remaining - 8'd1;
  assign w_rptr_inc = r_rptr + c_AW'(1);

  // Occupancy after this edge; a start flushes, push+pop together cancel
  always_comb begin
    w_count_next = r_count;
    if (w_start) begin
      w_count_next = '0;
    end else if (w_ack && !w_pop) begin
      w_count_next = r_count + c_CW'(1);
    end else if (!w_ack && w_pop) begin
      w_count_next = r_count - c_CW'(1);
    end
  end

  // Next state: a new read is only issued when its FIFO slot is guaranteed
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (line_start) begin
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        if (w_ack) begin
          if (w_rem_dec == 8'd0) begin
            w_state_next = IDLE;
          end else if (w_count_next < c_DEPTH) begin
            w_state_next = FETCH;
          end else begin
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_count_next < c_DEPTH) begin
          w_state_next = FETCH;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register; rd_req and busy are registered decodes of the next state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_rd_req <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rd_req <= (w_state_next == FETCH);
      r_busy   <= (w_state_next != IDLE);
    end
  end

  // Read address and bytes-left counter; the address wraps at 15 bits
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_start) begin
      r_addr      <= base_addr;
      r_remaining <= c_LINE;
    end else if (w_ack) begin
      r_addr      <= r_addr + 15'd1;
      r_remaining <= w_rem_dec;
    end
  end

  // FIFO storage needs no reset; only slots below the count are ever read
  always_ff @(posedge clk) begin
    if (w_ack) begin
      r_mem[r_wptr] <= ram_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_ack) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
      end
      r_count <= w_count_next;
    end
  end

  // Registered head byte: tracks whichever entry will be at the head after this edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pix_data <= '0;
    end else if (!w_start) begin
      if (w_pop) begin
        if (r_count == c_CW'(1)) begin
          if (w_ack) begin
            r_pix_data <= ram_data;
          end
        end else begin
          r_pix_data <= r_mem[w_rptr_inc];
        end
      end else if (w_empty && w_ack) begin
        r_pix_data <= ram_data;
      end
    end
  end

  // One-cycle error pulse for a pop on empty or a start while busy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (pix_pop && w_empty) || (line_start && r_busy);
    end
  end

  assign rd_addr   = r_addr;
  assign rd_req    = r_rd_req;
  assign busy      = r_busy;
  assign err       = r_err;
  assign pix_data  = r_pix_data;
  assign pix_valid = !w_empty;

endmodule
`default_nettype wire

// File: doc/video_fetch.md
VIDEO_FETCH -- requirements
Module: video_fetch

Interface
REQ-001 Parameter: LINE_BYTES, default 40, bytes fetched per line (1..255).
REQ-002 Parameter: FIFO_DEPTH, default 4, prefetch FIFO entries (power of two, 2..16).
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: nrst  in  1  reset; asynchronous, active-low.
REQ-005 Port: line_start  in  1  one-cycle pulse; start fetching a line.
REQ-006 Port: base_addr  in  15  first byte address of line; sampled when line_start is accepted.
REQ-007 Port: rd_addr  out  15  SRAM read address to the RAM controller read port.
REQ-008 Port: rd_req  out  1  read request to the RAM controller; registered.
REQ-009 Port: rd_ack  in  1  read complete; ram_data valid in the same cycle.
REQ-010 Port: ram_data  in  8  SRAM read data.
REQ-011 Port: pix_data  out  8  FIFO head byte.
REQ-012 Port: pix_valid  out  1  FIFO non-empty.
REQ-013 Port: pix_pop  in  1  consumer removes the head byte this cycle.
REQ-014 Port: busy  out  1  line fetch in progress.
REQ-015 Port: err  out  1  one-cycle pulse: pop on empty, or line_start while busy.

Function
REQ-016 States: IDLE, FETCH (request outstanding), HOLD (bytes remain, FIFO space exhausted).
REQ-017 IDLE + line_start: load addr=base_addr, remaining=LINE_BYTES, flush FIFO, go to FETCH with rd_req=1 next cycle; busy=1 from that cycle.
REQ-018 rd_req stays high and rd_addr stays stable until a cycle with rd_ack=1.
REQ-019 On rd_ack in FETCH: push ram_data, addr+1 (15-bit wrap, 7FFF->0000), remaining-1.
REQ-020 After an ack, rd_req is held high with the new address only if remaining>0 and post-edge FIFO count + 1 <= FIFO_DEPTH; otherwise rd_req=0.
REQ-021 At most one read outstanding; FIFO slot for an outstanding read is reserved, so a push never overflows.
REQ-022 remaining>0 but no space: HOLD with rd_req=0; leave HOLD and assert rd_req on the edge after the pop that frees a slot.
REQ-023 remaining reaches 0: go to IDLE, busy=0; FIFO contents stay poppable.
REQ-024 rd_ack in IDLE or HOLD is ignored.
REQ-025 pix_pop with pix_valid=1 removes the head; pix_pop with pix_valid=0 is ignored and err pulses.
REQ-026 Push and pop in the same cycle: both take effect, count unchanged; push into empty with pop is ignored as a pop (err).
REQ-027 line_start while busy is ignored and err pulses; an in-flight fetch is never aborted.
REQ-028 pix_data is registered FIFO-head data, valid whenever pix_valid=1; count width = log2(FIFO_DEPTH)+1.

Reset
REQ-029 nrst low asynchronously forces: state IDLE, rd_req=0, rd_addr=0, busy=0, err=0, pix_valid=0, pix_data=0, FIFO count=0, remaining=0.
REQ-030 Reset mid-transaction is permitted; a late rd_ack after reset is ignored per REQ-024.

Verification
REQ-031 Line of 40 from base 0x1000, ack 3 cycles after each request, pix_pop tied high -> 40 reads at 0x1000..0x1027 in order, 40 bytes out matching RAM, busy falls after 40th ack.
REQ-032 pix_pop=0, LINE_BYTES=40 -> exactly 4 reads issued, then rd_req=0 (HOLD); one pop -> rd_req=1 next cycle at base+4.
REQ-033 base_addr=0x7FFE, LINE_BYTES=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-034 line_start during busy; pop on empty FIFO -> one-cycle err each, fetch address sequence unchanged.
REQ-035 nrst pulsed low between request and rd_ack -> all outputs at reset values immediately; following rd_ack causes no push, pix_valid stays 0.
REQ-036 Simultaneous rd_ack and pix_pop with FIFO count 2 -> count remains 2, byte order preserved.
